// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared register file defaults and the hardwired-zero address
package reg_file_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_ZERO   = 0;
endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-writeback bit per register plus registered pending count
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sb_set,
  input  logic [ADDR_W-1:0]      sb_addr,
  input  logic                   clr,
  input  logic [ADDR_W-1:0]      clr_addr,
  output logic [2**ADDR_W-1:0]   pending,
  output logic [ADDR_W:0]        sb_cnt
);
  localparam int NUM_REGS = 2**ADDR_W;

  logic [NUM_REGS-1:0] pend_nxt;
  logic [ADDR_W:0]     cnt_nxt;

  // A set and a clear on the same register resolve to set: the new issue outlives the old return.
  always_comb begin
    pend_nxt = '0;
    cnt_nxt  = '0;
    for (int a = 0; a < NUM_REGS; a++) begin
      pend_nxt[a] = (sb_set && sb_addr == ADDR_W'(a)) |
                    (pending[a] & ~(clr && clr_addr == ADDR_W'(a)));
      if (ZERO_REG != 0 && a == REG_ZERO)
        pend_nxt[a] = 1'b0;
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, pend_nxt[a]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      sb_cnt  <= '0;
    end else begin
      pending <= pend_nxt;
      sb_cnt  <= cnt_nxt;
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-read dual-write register file with bypass and late-writeback scoreboard
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic [ADDR_W:0]          sb_cnt
);
  localparam int NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic                wr0_ok, wr1_ok;

  assign wr0_ok = we0 && !(ZERO_REG != 0 && wa0 == ZERO_ADDR);
  assign wr1_ok = we1 && !(ZERO_REG != 0 && wa1 == ZERO_ADDR);

  // Port 0 is written last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < NUM_REGS; a++)
        mem[a] <= '0;
    end else begin
      if (wr1_ok)
        mem[wa1] <= wd1;
      if (wr0_ok)
        mem[wa0] <= wd0;
    end
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .clr      (we1),
    .clr_addr (wa1),
    .pending  (pending),
    .sb_cnt   (sb_cnt)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_zero;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr    = rd_addr[k*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (addr == ZERO_ADDR);

    always_comb begin
      data = mem[addr];
      busy = pending[addr];
      if (BYPASS != 0 && !is_zero) begin
        if (we0 && wa0 == addr)
          data = wd0;
        else if (we1 && wa1 == addr)
          data = wd1;
        if (we1 && wa1 == addr)
          busy = 1'b0;
      end
      if (is_zero || !rst) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_busy[k]                  = busy;
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed self-checking bench for reg_file_sb (bypass and non-bypass builds)
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        rst;

  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        we0, we1, sb_set;
  logic [4:0]  wa0, wa1, sb_addr;
  logic [31:0] wd0, wd1;
  logic [5:0]  sb_cnt;

  logic [14:0] nb_rd_addr;
  logic [95:0] nb_rd_data;
  logic [2:0]  nb_rd_busy;
  logic        nb_we0, nb_we1, nb_sb_set;
  logic [4:0]  nb_wa0, nb_wa1, nb_sb_addr;
  logic [31:0] nb_wd0, nb_wd1;
  logic [5:0]  nb_sb_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_file_sb u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .sb_set(sb_set), .sb_addr(sb_addr), .sb_cnt(sb_cnt)
  );

  reg_file_sb #(.NUM_RD(3), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .rd_addr(nb_rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
    .we0(nb_we0), .wa0(nb_wa0), .wd0(nb_wd0), .we1(nb_we1), .wa1(nb_wa1), .wd1(nb_wd1),
    .sb_set(nb_sb_set), .sb_addr(nb_sb_addr), .sb_cnt(nb_sb_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; sb_set = 0; wa0 = 0; wa1 = 0; sb_addr = 0; wd0 = 0; wd1 = 0;
    nb_we0 = 0; nb_we1 = 0; nb_sb_set = 0; nb_wa0 = 0; nb_wa1 = 0; nb_sb_addr = 0;
    nb_wd0 = 0; nb_wd1 = 0;
  endtask

  // Advance across one rising edge and land just after the following falling edge.
  task automatic next();
    @(negedge clk);
    idle();
  endtask

  initial begin
    rst = 0;
    idle();
    rd_addr = {5'd3, 5'd1};
    nb_rd_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_data", rd_data, 64'h0);
    chk("reset_cnt", sb_cnt, 0);

    // 1: every register reads zero and idle after reset
    rst = 1;
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #1;
      chk($sformatf("rst_rd_%0d", a), rd_data, 64'h0);
      chk($sformatf("rst_busy_%0d", a), rd_busy, 0);
    end
    chk("rst_cnt", sb_cnt, 0);

    // 1b: asynchronous reset in the middle of a write
    next();
    we0 = 1; wa0 = 11; wd0 = 32'h77;
    next();
    rd_addr = {5'd10, 5'd11};
    #1 chk("pre_rst_r11", rd_data[31:0], 32'h77);
    we0 = 1; wa0 = 10; wd0 = 32'h1234; sb_set = 1; sb_addr = 12;
    #1 rst = 0;
    #1 chk("midrst_out", rd_data, 64'h0);
    chk("midrst_cnt", sb_cnt, 0);
    next();
    rst = 1;
    #1 chk("midrst_r11_r10", rd_data, 64'h0);
    rd_addr = {5'd12, 5'd12};
    #1 chk("midrst_busy12", rd_busy, 0);
    chk("midrst_cnt_after", sb_cnt, 0);

    // 2: port-0 bypass then storage
    next();
    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; rd_addr = {5'd6, 5'd5};
    #1 chk("byp0_same", rd_data[31:0], 32'hDEADBEEF);
    chk("byp0_other", rd_data[63:32], 32'h0);
    next();
    #1 chk("byp0_next", rd_data[31:0], 32'hDEADBEEF);

    // 3: dual write to a pending register, port 0 data wins, pending cleared
    sb_set = 1; sb_addr = 7;
    next();
    rd_addr = {5'd7, 5'd7};
    #1 chk("p3_busy_pre", rd_busy, 2'b11);
    chk("p3_cnt_pre", sb_cnt, 1);
    we0 = 1; we1 = 1; wa0 = 7; wa1 = 7; wd0 = 32'h1; wd1 = 32'h2;
    #1 chk("p3_same_data", rd_data, {32'h1, 32'h1});
    chk("p3_same_busy", rd_busy, 0);
    next();
    #1 chk("p3_next_data", rd_data, {32'h1, 32'h1});
    chk("p3_next_cnt", sb_cnt, 0);
    chk("p3_next_busy", rd_busy, 0);

    // 4: scoreboard set then late writeback with bypass
    sb_set = 1; sb_addr = 9;
    next();
    rd_addr = {5'd5, 5'd9};
    #1 chk("p4_busy", rd_busy, 2'b01);
    chk("p4_cnt", sb_cnt, 1);
    we1 = 1; wa1 = 9; wd1 = 32'hA5;
    #1 chk("p4_same_busy", rd_busy, 0);
    chk("p4_same_data", rd_data, {32'hDEADBEEF, 32'hA5});
    next();
    #1 chk("p4_next_cnt", sb_cnt, 0);
    chk("p4_next_data", rd_data[31:0], 32'hA5);

    // 5: set wins over clear, zero register, port 0 does not clear
    sb_set = 1; sb_addr = 3;
    next();
    #1 chk("p5_cnt1", sb_cnt, 1);
    sb_set = 1; sb_addr = 3; we1 = 1; wa1 = 3; wd1 = 32'h33;
    next();
    rd_addr = {5'd0, 5'd3};
    #1 chk("p5_setwins_cnt", sb_cnt, 1);
    chk("p5_setwins_busy", rd_busy, 2'b01);
    chk("p5_setwins_data", rd_data[31:0], 32'h33);
    sb_set = 1; sb_addr = 0;
    next();
    #1 chk("p5_zero_set_cnt", sb_cnt, 1);
    chk("p5_zero_busy", rd_busy[1], 1'b0);
    we0 = 1; wa0 = 0; wd0 = 32'hFFFF; we1 = 1; wa1 = 0; wd1 = 32'hBEEF;
    #1 chk("p5_zero_same", rd_data[63:32], 32'h0);
    next();
    #1 chk("p5_zero_next", rd_data[63:32], 32'h0);
    we0 = 1; wa0 = 3; wd0 = 32'h44;
    next();
    #1 chk("p5_we0_busy", rd_busy[0], 1'b1);
    chk("p5_we0_cnt", sb_cnt, 1);
    chk("p5_we0_data", rd_data[31:0], 32'h44);
    sb_set = 1; sb_addr = 20;
    next();
    #1 chk("p5_two_cnt", sb_cnt, 2);
    sb_set = 1; sb_addr = 20;
    next();
    #1 chk("p5_reset_same_cnt", sb_cnt, 2);

    // 6: no-bypass build, three read ports
    nb_we0 = 1; nb_wa0 = 4; nb_wd0 = 32'h55; nb_rd_addr = {5'd4, 5'd4, 5'd4};
    #1 chk("p6_same", nb_rd_data, 96'h0);
    next();
    #1 chk("p6_next", nb_rd_data, {32'h55, 32'h55, 32'h55});
    nb_sb_set = 1; nb_sb_addr = 4;
    next();
    #1 chk("p6_busy", nb_rd_busy, 3'b111);
    nb_we1 = 1; nb_wa1 = 4; nb_wd1 = 32'h66;
    #1 chk("p6_busy_nofwd", nb_rd_busy, 3'b111);
    chk("p6_data_nofwd", nb_rd_data, {32'h55, 32'h55, 32'h55});
    next();
    #1 chk("p6_late_data", nb_rd_data, {32'h66, 32'h66, 32'h66});
    chk("p6_late_busy", nb_rd_busy, 0);
    chk("p6_late_cnt", nb_sb_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
